// File: rtl/biquad_sched.sv
// Time-shared biquad scheduler: L-HP, L-LP, R-HP, R-LP on one MAC, with double-buffered coefficients.
// Latency: fixed 24 clk_48 cycles from accepted sample_valid to out_valid.
// Backpressure: none; a strobe while busy is dropped and flagged on overrun. BIQUAD_SCHED_SAT_EN selects clamping over wrap.
module biquad_sched #(
    parameter int COEF_W    = 64,
    parameter int COEF_FRAC = 30,
    parameter int ACC_W     = 84
) (
    input  logic              clk_48,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [15:0]       left_in,
    input  logic [15:0]       right_in,
    input  logic              coef_wr_en,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              coef_commit,
    output logic [15:0]       left_out,
    output logic [15:0]       right_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);
    localparam int PROD_W = COEF_W + 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0] state;
    logic [2:0] tap;
    logic [1:0] stage;

    logic signed [15:0] left_lat, right_lat, mid_res, left_res;
    logic signed [15:0] x1_st [4];
    logic signed [15:0] x2_st [4];
    logic signed [15:0] y1_st [4];
    logic signed [15:0] y2_st [4];

    logic signed [COEF_W-1:0] coef_shadow [10];
    logic signed [COEF_W-1:0] coef_active [10];
    logic signed [COEF_W-1:0] shadow_nxt  [10];
    logic                     pending;
    logic                     apply_ok;
    logic                     do_copy;

    logic signed [ACC_W-1:0]  acc;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [15:0]       x0_cur;
    logic signed [15:0]       op_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [15:0]       y_res;

    assign busy = (state != S_IDLE);

    // A same-edge write must be visible to a same-edge copy, so the copy reads the next shadow value.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            shadow_nxt[i] = coef_shadow[i];
            if (coef_wr_en && coef_addr == 4'(i))
                shadow_nxt[i] = $signed(coef_wdata);
        end
    end

    assign apply_ok = (state == S_IDLE) || (state == S_WB && stage == 2'd3);
    assign do_copy  = apply_ok && (pending || coef_commit);

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                coef_shadow[i] <= '0;
                coef_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 10; i++)
                coef_shadow[i] <= shadow_nxt[i];
            if (do_copy) begin
                for (int i = 0; i < 10; i++)
                    coef_active[i] <= shadow_nxt[i];
                pending <= 1'b0;
            end else if (coef_commit) begin
                pending <= 1'b1;
            end
        end
    end

    // HP stages take the latched input; LP stages take the HP result of the same channel.
    always_comb begin
        case (stage)
            2'd0:    x0_cur = left_lat;
            2'd2:    x0_cur = right_lat;
            default: x0_cur = mid_res;
        endcase
        case (tap)
            3'd0:    op_sel = x0_cur;
            3'd1:    op_sel = x1_st[stage];
            3'd2:    op_sel = x2_st[stage];
            3'd3:    op_sel = y1_st[stage];
            default: op_sel = y2_st[stage];
        endcase
        coef_sel = '0;
        for (int i = 0; i < 5; i++) begin
            if (tap == 3'(i))
                coef_sel = stage[0] ? coef_active[i+5] : coef_active[i];
        end
    end

    assign prod     = coef_sel * op_sel;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef BIQUAD_SCHED_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
    logic signed [ACC_W-1:0] acc_shr;

    assign acc_shr = acc >>> COEF_FRAC;

    always_comb begin
        if (acc_shr > SAT_MAX)
            y_res = 16'sh7fff;
        else if (acc_shr < SAT_MIN)
            y_res = 16'sh8000;
        else
            y_res = acc_shr[15:0];
    end
`else
    assign y_res = acc[COEF_FRAC +: 16];
`endif

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            tap       <= '0;
            stage     <= '0;
            acc       <= '0;
            left_lat  <= '0;
            right_lat <= '0;
            mid_res   <= '0;
            left_res  <= '0;
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x1_st[i] <= '0;
                x2_st[i] <= '0;
                y1_st[i] <= '0;
                y2_st[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample_valid && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        left_lat  <= $signed(left_in);
                        right_lat <= $signed(right_in);
                        tap       <= '0;
                        stage     <= '0;
                        state     <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    if (tap == 3'd4)
                        state <= S_WB;
                    else
                        tap <= tap + 3'd1;
                end
                S_WB: begin
                    acc           <= '0;
                    x2_st[stage]  <= x1_st[stage];
                    x1_st[stage]  <= x0_cur;
                    y2_st[stage]  <= y1_st[stage];
                    y1_st[stage]  <= y_res;
                    if (!stage[0])
                        mid_res <= y_res;
                    else if (stage == 2'd1)
                        left_res <= y_res;
                    tap <= '0;
                    if (stage == 2'd3) begin
                        left_out  <= left_res;
                        right_out <= y_res;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        stage <= stage + 2'd1;
                        state <= S_MAC;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_biquad_sched.sv
// Scoreboard bench for biquad_sched: expected outputs and due cycles queued at stimulus time.
// Each scenario task drives stimulus and checks its own timing-sensitive signals inline.
module tb_biquad_sched;
    logic        clk_48 = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic        coef_wr_en = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [63:0] coef_wdata = '0;
    logic        coef_commit = 1'b0;
    logic [15:0] left_out, right_out;
    logic        out_valid, busy, overrun;

    localparam logic [63:0] C1   = 64'h0000_0000_4000_0000;
    localparam logic [63:0] C05  = 64'h0000_0000_2000_0000;
    localparam logic [63:0] C4   = 64'h0000_0001_0000_0000;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ov_cnt = 0;

    always #5 clk_48 = ~clk_48;

    biquad_sched dut (
        .clk_48       (clk_48),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .left_in      (left_in),
        .right_in     (right_in),
        .coef_wr_en   (coef_wr_en),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .coef_commit  (coef_commit),
        .left_out     (left_out),
        .right_out    (right_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always @(posedge clk_48) cyc <= cyc + 1;

    always @(negedge clk_48) begin
        if (overrun) ov_cnt++;
        if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid cyc=%0d left=%0d right=%0d", cyc, $signed(left_out), $signed(right_out));
            end else begin
                mon_e = sb.pop_front();
                if (left_out !== mon_e.l) begin
                    errors++;
                    $display("FAIL left_out got=%0d exp=%0d", $signed(left_out), $signed(mon_e.l));
                end
                checks++;
                if (right_out !== mon_e.r) begin
                    errors++;
                    $display("FAIL right_out got=%0d exp=%0d", $signed(right_out), $signed(mon_e.r));
                end
                checks++;
                if (cyc !== mon_e.due) begin
                    errors++;
                    $display("FAIL out_valid_cycle got=%0d exp=%0d", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] l, input logic [15:0] r, input int due);
        exp_t e;
        e.l = l;
        e.r = r;
        e.due = due;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_48);
        reset_n = 1'b0;
        sample_valid = 1'b0;
        coef_wr_en = 1'b0;
        coef_commit = 1'b0;
        repeat (3) @(negedge clk_48);
        reset_n = 1'b1;
        @(negedge clk_48);
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [63:0] d, input logic cm);
        @(negedge clk_48);
        coef_wr_en = 1'b1;
        coef_addr = a;
        coef_wdata = d;
        coef_commit = cm;
        @(negedge clk_48);
        coef_wr_en = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic setup_pass();
        write_coef(4'd0, C1, 1'b0);
        write_coef(4'd5, C1, 1'b1);
    endtask

    // Returns the bench cycle count observed just after the accepting edge.
    task automatic send_sample(input logic [15:0] l, input logic [15:0] r, input logic cm, output int c0);
        @(negedge clk_48);
        sample_valid = 1'b1;
        left_in = l;
        right_in = r;
        coef_commit = cm;
        @(negedge clk_48);
        sample_valid = 1'b0;
        coef_commit = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk_48);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
        @(negedge clk_48);
    endtask

    task automatic test_reset();
        @(negedge clk_48);
        checks++;
        if (left_out !== 16'd0 || right_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%0d/%0d exp=0/0", left_out, right_out);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b%b%b exp=000", out_valid, busy, overrun);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk_48);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b%b exp=00", busy, out_valid);
        end
    endtask

    task automatic test_passthrough();
        int c0;
        do_reset();
        setup_pass();
        send_sample(16'd1234, 16'(-500), 1'b0, c0);
        push_exp(16'd1234, 16'(-500), c0 + 24);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_e0 got=%b exp=1", busy);
        end
        while (cyc < c0 + 23) @(negedge clk_48);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_e24 got=%b exp=1", busy);
        end
        @(negedge clk_48);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_e24 got=%b exp=0", busy);
        end
        wait_drain(40);
    endtask

    task automatic test_saturation();
        int c0;
        do_reset();
        write_coef(4'd0, C4, 1'b0);
        write_coef(4'd5, C1, 1'b1);
        send_sample(16'd20000, 16'(-10000), 1'b0, c0);
`ifdef BIQUAD_SCHED_SAT_EN
        push_exp(16'd32767, 16'(-32768), c0 + 24);
`else
        push_exp(16'd14464, 16'd25536, c0 + 24);
`endif
        wait_drain(40);
    endtask

    task automatic test_recursion();
        int c0;
        do_reset();
        write_coef(4'd0, C1, 1'b0);
        write_coef(4'd3, C05, 1'b0);
        write_coef(4'd5, C1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_sample((i == 0) ? 16'd16384 : 16'd0, 16'd0, 1'b0, c0);
            push_exp(16'(16384 >> i), 16'd0, c0 + 24);
            wait_drain(40);
        end
    endtask

    task automatic test_commit_busy();
        int c0;
        do_reset();
        setup_pass();
        send_sample(16'd1000, 16'(-2000), 1'b0, c0);
        push_exp(16'd1000, 16'(-2000), c0 + 24);
        repeat (4) @(negedge clk_48);
        coef_wr_en = 1'b1;
        coef_addr = 4'd0;
        coef_wdata = C05;
        coef_commit = 1'b1;
        @(negedge clk_48);
        coef_wr_en = 1'b0;
        coef_commit = 1'b0;
        wait_drain(40);
        // Shadow-only write: must not reach the next sample.
        write_coef(4'd5, C05, 1'b0);
        send_sample(16'd1000, 16'(-2000), 1'b0, c0);
        push_exp(16'd500, 16'(-1000), c0 + 24);
        wait_drain(40);
        send_sample(16'd1000, 16'(-2000), 1'b1, c0);
        push_exp(16'd250, 16'(-500), c0 + 24);
        wait_drain(40);
    endtask

    task automatic test_overrun();
        int c0;
        int ov0;
        do_reset();
        setup_pass();
        ov0 = ov_cnt;
        send_sample(16'd100, 16'd200, 1'b0, c0);
        push_exp(16'd100, 16'd200, c0 + 24);
        repeat (9) @(negedge clk_48);
        sample_valid = 1'b1;
        left_in = 16'd7777;
        right_in = 16'd7777;
        @(negedge clk_48);
        sample_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse got=%b exp=1", overrun);
        end
        @(negedge clk_48);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_one_cycle got=%b exp=0", overrun);
        end
        wait_drain(40);
        checks++;
        if (ov_cnt - ov0 !== 1) begin
            errors++;
            $display("FAIL overrun_count got=%0d exp=1", ov_cnt - ov0);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        int ov0;
        ov0 = ov_cnt;
        send_sample(16'd300, 16'(-300), 1'b0, c0);
        push_exp(16'd300, 16'(-300), c0 + 24);
        while (cyc < c0 + 23) @(negedge clk_48);
        sample_valid = 1'b1;
        left_in = 16'd999;
        right_in = 16'd999;
        @(negedge clk_48);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_at_e24 got=%b exp=1", overrun);
        end
        left_in = 16'd400;
        right_in = 16'(-400);
        @(negedge clk_48);
        sample_valid = 1'b0;
        c1 = cyc;
        push_exp(16'd400, 16'(-400), c1 + 24);
        checks++;
        if (busy !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL accept_at_e25 got=busy%b ovr%b exp=busy1 ovr0", busy, overrun);
        end
        wait_drain(60);
        checks++;
        if (ov_cnt - ov0 !== 1) begin
            errors++;
            $display("FAIL b2b_overrun_count got=%0d exp=1", ov_cnt - ov0);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        do_reset();
        setup_pass();
        send_sample(16'd1234, 16'(-500), 1'b0, c0);
        push_exp(16'd1234, 16'(-500), c0 + 24);
        wait_drain(40);
        send_sample(16'd1111, 16'd2222, 1'b0, c0);
        repeat (11) @(negedge clk_48);
        reset_n = 1'b0;
        #1;
        checks++;
        if (left_out !== 16'd0 || right_out !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs got=%0d/%0d exp=0/0", left_out, right_out);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags got=%b%b%b exp=000", out_valid, busy, overrun);
        end
        @(negedge clk_48);
        reset_n = 1'b1;
        repeat (30) @(negedge clk_48);
        send_sample(16'd1234, 16'(-500), 1'b0, c0);
        push_exp(16'd0, 16'd0, c0 + 24);
        wait_drain(40);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_saturation();
        test_recursion();
        test_commit_busy();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
